// File: rtl/jb_eth_lpbk_arb.sv
// ============================================================================
// Module   : jb_eth_lpbk_arb
// Brief    : Frame-aware 2:1 AXIS selector feeding the Ethernet core TX port.
//            s0 = O-RAN IF TX, s1 = Ethernet core RX (loopback). Optional frame
//            statistics are built when JB_LPBK_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jb_eth_lpbk_arb #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int USER_W = 31,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lpbk_req_i,
    input  logic              stat_clr_i,
    // s0: O-RAN IF TX
    input  logic [DATA_W-1:0] oran_if_tx_tdata_i,
    input  logic [KEEP_W-1:0] oran_if_tx_tkeep_i,
    input  logic              oran_if_tx_tvalid_i,
    input  logic              oran_if_tx_tlast_i,
    input  logic [USER_W-1:0] oran_if_tx_tuser_i,
    output logic              oran_if_tx_tready_o,
    // s1: Ethernet core RX
    input  logic [DATA_W-1:0] eth_core_rx_tdata_i,
    input  logic [KEEP_W-1:0] eth_core_rx_tkeep_i,
    input  logic              eth_core_rx_tvalid_i,
    input  logic              eth_core_rx_tlast_i,
    input  logic [USER_W-1:0] eth_core_rx_tuser_i,
    output logic              eth_core_rx_tready_o,
    // m: Ethernet core TX
    output logic [DATA_W-1:0] eth_core_tx_tdata_o,
    output logic [KEEP_W-1:0] eth_core_tx_tkeep_o,
    output logic              eth_core_tx_tvalid_o,
    output logic              eth_core_tx_tlast_o,
    output logic [USER_W-1:0] eth_core_tx_tuser_o,
    input  logic              eth_core_tx_tready_i,
    // status
    output logic              lpbk_active_o,
    output logic              switch_pending_o,
    output logic [CNT_W-1:0]  cnt_oran_frm_o,
    output logic [CNT_W-1:0]  cnt_lpbk_frm_o,
    output logic [CNT_W-1:0]  cnt_rx_drop_frm_o
);

    typedef enum logic [1:0] {
        ST_NORM     = 2'd0,
        ST_NORM_DRN = 2'd1,
        ST_LPBK     = 2'd2,
        ST_LPBK_DRN = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   s0_inf_q, s1_inf_q;
    logic   sel_lpbk;
    logic   s0_acc, s1_acc;
    logic   boundary;

    assign sel_lpbk = (state_q == ST_LPBK) || (state_q == ST_LPBK_DRN);

    // Combinational datapath; handshakes are forced low while in reset.
    assign eth_core_tx_tdata_o  = sel_lpbk ? eth_core_rx_tdata_i : oran_if_tx_tdata_i;
    assign eth_core_tx_tkeep_o  = sel_lpbk ? eth_core_rx_tkeep_i : oran_if_tx_tkeep_i;
    assign eth_core_tx_tlast_o  = sel_lpbk ? eth_core_rx_tlast_i : oran_if_tx_tlast_i;
    assign eth_core_tx_tuser_o  = sel_lpbk ? eth_core_rx_tuser_i : oran_if_tx_tuser_i;
    assign eth_core_tx_tvalid_o = rst_n & (sel_lpbk ? eth_core_rx_tvalid_i : oran_if_tx_tvalid_i);
    assign oran_if_tx_tready_o  = rst_n & ~sel_lpbk & eth_core_tx_tready_i;
    assign eth_core_rx_tready_o = rst_n & (sel_lpbk ? eth_core_tx_tready_i : 1'b1);

    assign s0_acc   = oran_if_tx_tvalid_i  & oran_if_tx_tready_o;
    assign s1_acc   = eth_core_rx_tvalid_i & eth_core_rx_tready_o;
    assign boundary = ~s0_inf_q & ~s1_inf_q & ~s0_acc & ~s1_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_NORM;
            s0_inf_q <= 1'b0;
            s1_inf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (s0_acc) s0_inf_q <= ~oran_if_tx_tlast_i;
            if (s1_acc) s1_inf_q <= ~eth_core_rx_tlast_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORM:     if (lpbk_req_i) state_d = ST_NORM_DRN;
            ST_NORM_DRN: begin
                if (!lpbk_req_i)   state_d = ST_NORM;
                else if (boundary) state_d = ST_LPBK;
            end
            ST_LPBK:     if (!lpbk_req_i) state_d = ST_LPBK_DRN;
            ST_LPBK_DRN: begin
                if (lpbk_req_i)    state_d = ST_LPBK;
                else if (boundary) state_d = ST_NORM;
            end
            default:     state_d = ST_NORM;
        endcase
    end

    assign lpbk_active_o    = sel_lpbk;
    assign switch_pending_o = (state_q == ST_NORM_DRN) || (state_q == ST_LPBK_DRN);

`ifdef JB_LPBK_STATS_EN
    logic [CNT_W-1:0] cnt_oran_q, cnt_lpbk_q, cnt_drop_q;
    logic             inc_oran, inc_lpbk, inc_drop;

    // s0 is only accepted in the NORM states, so its tlast always counts as forwarded.
    assign inc_oran = s0_acc & oran_if_tx_tlast_i;
    assign inc_lpbk = s1_acc & eth_core_rx_tlast_i &  sel_lpbk;
    assign inc_drop = s1_acc & eth_core_rx_tlast_i & ~sel_lpbk;

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr_i) begin
            cnt_oran_q <= '0;
            cnt_lpbk_q <= '0;
            cnt_drop_q <= '0;
        end else begin
            if (inc_oran && cnt_oran_q != '1) cnt_oran_q <= cnt_oran_q + 1'b1;
            if (inc_lpbk && cnt_lpbk_q != '1) cnt_lpbk_q <= cnt_lpbk_q + 1'b1;
            if (inc_drop && cnt_drop_q != '1) cnt_drop_q <= cnt_drop_q + 1'b1;
        end
    end

    assign cnt_oran_frm_o    = cnt_oran_q;
    assign cnt_lpbk_frm_o    = cnt_lpbk_q;
    assign cnt_rx_drop_frm_o = cnt_drop_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr   = stat_clr_i;
    assign cnt_oran_frm_o    = '0;
    assign cnt_lpbk_frm_o    = '0;
    assign cnt_rx_drop_frm_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jb_eth_lpbk_arb.sv
// ============================================================================
// Module   : tb_jb_eth_lpbk_arb
// Brief    : Directed self-checking bench for jb_eth_lpbk_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jb_eth_lpbk_arb;

`ifdef JB_LPBK_STATS_EN
    localparam int c_STATS = 1;
`else
    localparam int c_STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lpbk_req, stat_clr;
    logic [63:0] s0_tdata, s1_tdata, m_tdata;
    logic [7:0]  s0_tkeep, s1_tkeep, m_tkeep;
    logic        s0_tvalid, s1_tvalid, m_tvalid;
    logic        s0_tlast, s1_tlast, m_tlast;
    logic [30:0] s0_tuser, s1_tuser, m_tuser;
    logic        s0_tready, s1_tready, m_tready;
    logic        lpbk_active, switch_pending;
    logic [31:0] cnt_oran, cnt_lpbk, cnt_drop;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jb_eth_lpbk_arb dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .lpbk_req_i           (lpbk_req),
        .stat_clr_i           (stat_clr),
        .oran_if_tx_tdata_i   (s0_tdata),
        .oran_if_tx_tkeep_i   (s0_tkeep),
        .oran_if_tx_tvalid_i  (s0_tvalid),
        .oran_if_tx_tlast_i   (s0_tlast),
        .oran_if_tx_tuser_i   (s0_tuser),
        .oran_if_tx_tready_o  (s0_tready),
        .eth_core_rx_tdata_i  (s1_tdata),
        .eth_core_rx_tkeep_i  (s1_tkeep),
        .eth_core_rx_tvalid_i (s1_tvalid),
        .eth_core_rx_tlast_i  (s1_tlast),
        .eth_core_rx_tuser_i  (s1_tuser),
        .eth_core_rx_tready_o (s1_tready),
        .eth_core_tx_tdata_o  (m_tdata),
        .eth_core_tx_tkeep_o  (m_tkeep),
        .eth_core_tx_tvalid_o (m_tvalid),
        .eth_core_tx_tlast_o  (m_tlast),
        .eth_core_tx_tuser_o  (m_tuser),
        .eth_core_tx_tready_i (m_tready),
        .lpbk_active_o        (lpbk_active),
        .switch_pending_o     (switch_pending),
        .cnt_oran_frm_o       (cnt_oran),
        .cnt_lpbk_frm_o       (cnt_lpbk),
        .cnt_rx_drop_frm_o    (cnt_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_s0(input logic v, input logic [63:0] d, input logic l);
        s0_tvalid = v; s0_tdata = d; s0_tlast = l;
        s0_tkeep  = 8'hff; s0_tuser = d[30:0];
    endtask

    task automatic drv_s1(input logic v, input logic [63:0] d, input logic l);
        s1_tvalid = v; s1_tdata = d; s1_tlast = l;
        s1_tkeep  = 8'h0f; s1_tuser = ~d[30:0];
    endtask

    task automatic chk_m(input string tag, input logic [63:0] d, input logic l);
        chk({tag, "_vld"},  {63'd0, m_tvalid}, 64'd1);
        chk({tag, "_data"}, m_tdata, d);
        chk({tag, "_last"}, {63'd0, m_tlast}, {63'd0, l});
    endtask

    initial begin
        rst_n = 1'b0; lpbk_req = 1'b0; stat_clr = 1'b0; m_tready = 1'b1;
        drv_s0(1'b1, 64'h55, 1'b0);
        drv_s1(1'b1, 64'h66, 1'b0);
        @(negedge clk);
        chk("rst_s0_rdy", {63'd0, s0_tready}, 64'd0);
        chk("rst_s1_rdy", {63'd0, s1_tready}, 64'd0);
        chk("rst_m_vld",  {63'd0, m_tvalid},  64'd0);
        tick(); tick();
        @(negedge clk);
        chk("rst_active",  {63'd0, lpbk_active},    64'd0);
        chk("rst_pending", {63'd0, switch_pending}, 64'd0);
        chk("rst_cnt_oran", {32'd0, cnt_oran}, 64'd0);
        rst_n = 1'b1;
        drv_s0(1'b0, 64'h0, 1'b0);
        drv_s1(1'b0, 64'h0, 1'b0);

        // 4-beat s0 frame, 0 latency, bit-exact
        for (int i = 0; i < 4; i++) begin
            drv_s0(1'b1, 64'h1000 + 64'(i), i == 3);
            @(negedge clk);
            chk_m("t1", 64'h1000 + 64'(i), i == 3);
            chk("t1_keep", {56'd0, m_tkeep}, 64'hff);
            chk("t1_user", {33'd0, m_tuser}, 64'h1000 + 64'(i));
            chk("t1_s0_rdy", {63'd0, s0_tready}, 64'd1);
            tick();
        end
        drv_s0(1'b0, 64'h0, 1'b0);
        @(negedge clk);
        chk("t1_cnt_oran", {32'd0, cnt_oran}, 64'(c_STATS));
        chk("t1_s1_rdy", {63'd0, s1_tready}, 64'd1);
        tick();

        // lpbk_req during a 6-beat s0 frame
        for (int i = 0; i < 6; i++) begin
            if (i == 2) lpbk_req = 1'b1;
            drv_s0(1'b1, 64'h2000 + 64'(i), i == 5);
            @(negedge clk);
            chk_m("t2", 64'h2000 + 64'(i), i == 5);
            chk("t2_active", {63'd0, lpbk_active}, 64'd0);
            if (i >= 3) chk("t2_pending", {63'd0, switch_pending}, 64'd1);
            tick();
        end
        drv_s0(1'b0, 64'h0, 1'b0);
        @(negedge clk);
        chk("t2_active_b", {63'd0, lpbk_active},    64'd0);
        chk("t2_pend_b",   {63'd0, switch_pending}, 64'd1);
        tick();
        @(negedge clk);
        chk("t2_active_c", {63'd0, lpbk_active},    64'd1);
        chk("t2_pend_c",   {63'd0, switch_pending}, 64'd0);

        // LPBK: s0 stalled, request dropped mid s1 frame
        drv_s0(1'b1, 64'hDEAD, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) lpbk_req = 1'b0;
            drv_s1(1'b1, 64'h3000 + 64'(i), i == 3);
            @(negedge clk);
            chk_m("t4", 64'h3000 + 64'(i), i == 3);
            chk("t4_s0_rdy", {63'd0, s0_tready},   64'd0);
            chk("t4_active", {63'd0, lpbk_active}, 64'd1);
            if (i == 3) chk("t4_pending", {63'd0, switch_pending}, 64'd1);
            tick();
        end
        drv_s1(1'b0, 64'h0, 1'b0);
        @(negedge clk);
        chk("t4_m_idle", {63'd0, m_tvalid}, 64'd0);
        chk("t4_active_b", {63'd0, lpbk_active}, 64'd1);
        tick();
        @(negedge clk);
        chk("t4_active_c", {63'd0, lpbk_active}, 64'd0);
        chk_m("t4_s0", 64'hDEAD, 1'b1);
        chk("t4_s0_rdy_c", {63'd0, s0_tready}, 64'd1);
        tick();
        drv_s0(1'b0, 64'h0, 1'b0);
        @(negedge clk);
        chk("t4_cnt_lpbk", {32'd0, cnt_lpbk}, 64'(c_STATS));
        chk("t4_cnt_oran", {32'd0, cnt_oran}, 64'(3 * c_STATS));

        // NORM: s1 mid-frame when request rises -> frame dropped
        for (int i = 0; i < 5; i++) begin
            if (i == 2) lpbk_req = 1'b1;
            drv_s1(1'b1, 64'h4000 + 64'(i), i == 4);
            @(negedge clk);
            chk("t3_s1_rdy", {63'd0, s1_tready},   64'd1);
            chk("t3_m_vld",  {63'd0, m_tvalid},    64'd0);
            chk("t3_active", {63'd0, lpbk_active}, 64'd0);
            tick();
        end
        drv_s1(1'b0, 64'h0, 1'b0);
        @(negedge clk);
        chk("t3_active_b", {63'd0, lpbk_active}, 64'd0);
        tick();
        @(negedge clk);
        chk("t3_active_c", {63'd0, lpbk_active}, 64'd1);
        chk("t3_cnt_drop", {32'd0, cnt_drop}, 64'(c_STATS));
        for (int i = 0; i < 2; i++) begin
            drv_s1(1'b1, 64'h4100 + 64'(i), i == 1);
            @(negedge clk);
            chk_m("t3_next", 64'h4100 + 64'(i), i == 1);
            chk("t3_user", {33'd0, m_tuser}, {33'd0, ~(31'h4100 + 31'(i))});
            tick();
        end

        // Backpressure in LPBK with lpbk_req toggling
        drv_s1(1'b1, 64'h5000, 1'b0);
        tick();
        drv_s1(1'b1, 64'h5001, 1'b0);
        m_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            lpbk_req = (k % 2 == 1);
            @(negedge clk);
            chk("t5l_data",   m_tdata, 64'h5001);
            chk("t5l_s1_rdy", {63'd0, s1_tready},   64'd0);
            chk("t5l_active", {63'd0, lpbk_active}, 64'd1);
            tick();
        end
        lpbk_req = 1'b1; m_tready = 1'b1;
        tick();
        lpbk_req = 1'b0;
        drv_s1(1'b1, 64'h5002, 1'b1);
        tick();
        drv_s1(1'b0, 64'h0, 1'b0);
        tick(); tick();
        @(negedge clk);
        chk("t5_to_norm", {63'd0, lpbk_active}, 64'd0);
        chk("t5_cnt_lpbk", {32'd0, cnt_lpbk}, 64'(3 * c_STATS));

        // Backpressure in NORM with lpbk_req toggling
        drv_s0(1'b1, 64'h6000, 1'b0);
        tick();
        drv_s0(1'b1, 64'h6001, 1'b0);
        m_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            lpbk_req = (k % 2 == 0);
            @(negedge clk);
            chk("t5n_data",   m_tdata, 64'h6001);
            chk("t5n_s0_rdy", {63'd0, s0_tready},   64'd0);
            chk("t5n_active", {63'd0, lpbk_active}, 64'd0);
            tick();
        end
        lpbk_req = 1'b0; m_tready = 1'b1;
        tick();
        drv_s0(1'b1, 64'h6002, 1'b1);
        tick();
        drv_s0(1'b0, 64'h0, 1'b0);
        @(negedge clk);
        chk("t5_cnt_oran", {32'd0, cnt_oran}, 64'(4 * c_STATS));

        // Statistics clear
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_cnt_oran", {32'd0, cnt_oran}, 64'd0);
        chk("clr_cnt_lpbk", {32'd0, cnt_lpbk}, 64'd0);

        // Reset at beat 3 of an LPBK frame
        lpbk_req = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("t6_active", {63'd0, lpbk_active}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            drv_s1(1'b1, 64'h7000 + 64'(i), 1'b0);
            if (i == 2) begin
                rst_n = 1'b0;
                drv_s0(1'b1, 64'h7777, 1'b1);
            end
            @(negedge clk);
            if (i == 2) begin
                chk("t6_rst_s0_rdy", {63'd0, s0_tready}, 64'd0);
                chk("t6_rst_s1_rdy", {63'd0, s1_tready}, 64'd0);
                chk("t6_rst_m_vld",  {63'd0, m_tvalid},  64'd0);
            end else begin
                chk_m("t6", 64'h7000 + 64'(i), 1'b0);
            end
            tick();
        end
        lpbk_req = 1'b0;
        @(negedge clk);
        chk("t6_rst_active",  {63'd0, lpbk_active},    64'd0);
        chk("t6_rst_pending", {63'd0, switch_pending}, 64'd0);
        chk("t6_rst_cnt",     {32'd0, cnt_lpbk},       64'd0);
        tick();
        rst_n = 1'b1;
        drv_s0(1'b0, 64'h0, 1'b0);
        drv_s1(1'b0, 64'h0, 1'b0);
        @(negedge clk);
        chk("t6_post_s1_rdy", {63'd0, s1_tready}, 64'd1);
        tick();
        lpbk_req = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("t6_flags_clr", {63'd0, lpbk_active}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
